// File: rtl/am_dds_if.sv
// am_dds_if
// Groups the control, configuration and sample-output signals of the AM DDS
// modulator into one bundle. The master side is the block that drives the
// enables and configuration. The slave side is the modulator itself.
//
// Signals
//   en               advance accumulators and launch one sample
//   sync_clr         zero both phase accumulators
//   cfg_load         copy cfg_* into the active configuration
//   cfg_fcw_carrier  carrier frequency control word
//   cfg_fcw_env      envelope frequency control word
//   cfg_mod_index    modulation index, unsigned Q1.(M_W-1)
//   cfg_mode_sc      0 = full carrier, 1 = suppressed carrier
//   sin_carrier      signed carrier sample
//   sin_env          signed envelope sample
//   am_out           signed, saturated modulated sample
//   out_valid        outputs carry a new sample this cycle
//   sat              am_out was clipped for this sample
interface am_dds_if #(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 16,
  parameter int M_W     = 8,
  parameter int OUT_W   = 17
);

  logic                      en;
  logic                      sync_clr;
  logic                      cfg_load;
  logic [PHASE_W-1:0]        cfg_fcw_carrier;
  logic [PHASE_W-1:0]        cfg_fcw_env;
  logic [M_W-1:0]            cfg_mod_index;
  logic                      cfg_mode_sc;
  logic signed [DATA_W-1:0]  sin_carrier;
  logic signed [DATA_W-1:0]  sin_env;
  logic signed [OUT_W-1:0]   am_out;
  logic                      out_valid;
  logic                      sat;

  modport master (
    output en,
    output sync_clr,
    output cfg_load,
    output cfg_fcw_carrier,
    output cfg_fcw_env,
    output cfg_mod_index,
    output cfg_mode_sc,
    input  sin_carrier,
    input  sin_env,
    input  am_out,
    input  out_valid,
    input  sat
  );

  modport slave (
    input  en,
    input  sync_clr,
    input  cfg_load,
    input  cfg_fcw_carrier,
    input  cfg_fcw_env,
    input  cfg_mod_index,
    input  cfg_mode_sc,
    output sin_carrier,
    output sin_env,
    output am_out,
    output out_valid,
    output sat
  );

endinterface

// File: rtl/am_dds_modulator.sv
// am_dds_modulator
// Two-channel DDS amplitude modulator. A carrier and an envelope phase
// accumulator each address a quarter-wave sine table. The envelope is scaled
// by a runtime modulation index and, in full-carrier mode, offset by the sine
// full scale. The result multiplies the carrier sample. The product is
// rescaled, saturated to OUT_W bits and presented with a valid strobe four
// edges after the enable that launched it.
//
// Ports
//   clk      rising-edge clock for all state
//   rst      synchronous active-high reset
//   ddsBus   am_dds_if slave: en/sync_clr/cfg_* in, samples/valid/sat out
module am_dds_modulator #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int DATA_W  = 16,
  parameter int M_W     = 8,
  parameter int OUT_W   = 17
) (
  input  logic     clk,
  input  logic     rst,
  am_dds_if.slave  ddsBus
);

  localparam int LUT_N  = 2 ** LUT_AW;
  localparam int FS_INT = (2 ** (DATA_W - 1)) - 1;
  localparam int ENV_W  = DATA_W + 2;
  localparam int MUL_W  = DATA_W + M_W + 1;
  localparam int PROD_W = DATA_W + ENV_W;

  localparam logic [M_W-1:0]            M_ONE   = M_W'(1) << (M_W - 1);
  localparam logic signed [ENV_W-1:0]   FS_ENV  = ENV_W'(FS_INT);
  localparam logic signed [PROD_W-1:0]  OUT_MAX = (PROD_W'(1) <<< (OUT_W - 1)) - PROD_W'(1);
  localparam logic signed [PROD_W-1:0]  OUT_MIN = -(PROD_W'(1) <<< (OUT_W - 1));

  // Table contents are fixed at elaboration: round(FS*sin(pi/2*i/N)) for
  // each quarter-wave entry. The argument never exceeds pi/2, so the value
  // is non-negative and adding one half before truncation rounds it.
  function automatic logic signed [DATA_W-1:0] lutValue(input int idx);
    real angle;
    angle = 3.14159265358979323846 / 2.0 * real'(idx) / real'(LUT_N);
    return DATA_W'($rtoi(real'(FS_INT) * $sin(angle) + 0.5));
  endfunction

  logic signed [DATA_W-1:0] sineRom [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : gRom
    assign sineRom[g] = lutValue(g);
  end

  logic [PHASE_W-1:0]        fcwCarrier_q, fcwCarrier_d;
  logic [PHASE_W-1:0]        fcwEnv_q, fcwEnv_d;
  logic [M_W-1:0]            modIndex_q, modIndex_d;
  logic                      modeSc_q, modeSc_d;

  logic [PHASE_W-1:0]        accCarrier_q, accCarrier_d;
  logic [PHASE_W-1:0]        accEnv_q, accEnv_d;

  logic [LUT_AW-1:0]         addrCarrier, addrEnv;
  logic signed [DATA_W-1:0]  romCarrier, romEnv;
  logic signed [DATA_W-1:0]  sinCarrier, sinEnv;

  logic                      valid1_q, valid2_q, valid3_q;
  logic signed [DATA_W-1:0]  carrier1_q, carrier2_q, carrier3_q;
  logic signed [DATA_W-1:0]  env1_q, env2_q, env3_q;
  logic [M_W-1:0]            modIndex1_q;
  logic                      modeSc1_q;

  logic signed [MUL_W-1:0]   envScaled;
  logic signed [ENV_W-1:0]   envTerm;
  logic signed [ENV_W-1:0]   envelope_d, envelope2_q;
  logic signed [PROD_W-1:0]  product3_q;

  logic signed [PROD_W-1:0]  rescaled;
  logic signed [OUT_W-1:0]   amOut_d;
  logic                      sat_d;

  logic                      outValid_q;
  logic                      sat_q;
  logic signed [OUT_W-1:0]   amOut_q;
  logic signed [DATA_W-1:0]  sinCarrierOut_q, sinEnvOut_q;

  // Active configuration. A load takes effect for the next edge, so an
  // enable on the same edge still advances the accumulators with the old
  // frequency words.
  always_comb begin
    fcwCarrier_d = fcwCarrier_q;
    fcwEnv_d     = fcwEnv_q;
    modIndex_d   = modIndex_q;
    modeSc_d     = modeSc_q;
    if (ddsBus.cfg_load) begin
      fcwCarrier_d = ddsBus.cfg_fcw_carrier;
      fcwEnv_d     = ddsBus.cfg_fcw_env;
      modIndex_d   = ddsBus.cfg_mod_index;
      modeSc_d     = ddsBus.cfg_mode_sc;
    end
  end

  // Configuration register. After reset the block runs at zero frequency
  // with unity modulation index in full-carrier mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcwCarrier_q <= '0;
      fcwEnv_q     <= '0;
      modIndex_q   <= M_ONE;
      modeSc_q     <= 1'b0;
    end else begin
      fcwCarrier_q <= fcwCarrier_d;
      fcwEnv_q     <= fcwEnv_d;
      modIndex_q   <= modIndex_d;
      modeSc_q     <= modeSc_d;
    end
  end

  // Phase accumulators. A clear overrides the enable. Overflow simply wraps
  // around the circle, which is the intended modulo behaviour.
  always_comb begin
    accCarrier_d = accCarrier_q;
    accEnv_d     = accEnv_q;
    if (ddsBus.sync_clr) begin
      accCarrier_d = '0;
      accEnv_d     = '0;
    end else if (ddsBus.en) begin
      accCarrier_d = accCarrier_q + fcwCarrier_q;
      accEnv_d     = accEnv_q + fcwEnv_q;
    end
  end

  // Phase accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      accCarrier_q <= '0;
      accEnv_q     <= '0;
    end else begin
      accCarrier_q <= accCarrier_d;
      accEnv_q     <= accEnv_d;
    end
  end

  // Quarter-wave folding. The top bit selects the negative half-cycle. The
  // next bit selects a falling quadrant, where the table is read backwards
  // by inverting the address. The lookup uses the pre-increment phase, so
  // the sample launched alongside a clear still sees the old phase.
  always_comb begin
    addrCarrier = accCarrier_q[PHASE_W-3 -: LUT_AW];
    addrEnv     = accEnv_q[PHASE_W-3 -: LUT_AW];
    if (accCarrier_q[PHASE_W-2]) begin
      addrCarrier = ~addrCarrier;
    end
    if (accEnv_q[PHASE_W-2]) begin
      addrEnv = ~addrEnv;
    end
    romCarrier = sineRom[addrCarrier];
    romEnv     = sineRom[addrEnv];
    sinCarrier = accCarrier_q[PHASE_W-1] ? -romCarrier : romCarrier;
    sinEnv     = accEnv_q[PHASE_W-1] ? -romEnv : romEnv;
  end

  // Stage 1 captures both sine samples. It also snapshots the modulation
  // settings, so a reload while samples are in flight cannot mix two
  // configurations within one sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q    <= 1'b0;
      carrier1_q  <= '0;
      env1_q      <= '0;
      modIndex1_q <= '0;
      modeSc1_q   <= 1'b0;
    end else begin
      valid1_q    <= ddsBus.en;
      carrier1_q  <= sinCarrier;
      env1_q      <= sinEnv;
      modIndex1_q <= modIndex_q;
      modeSc1_q   <= modeSc_q;
    end
  end

  // Envelope scaling. The index is unsigned, so it gets a zero sign bit
  // before a signed multiply. The arithmetic shift floors toward minus
  // infinity. Full-carrier mode adds the sine full scale so the envelope
  // rides on a DC pedestal. ENV_W leaves headroom for m close to 2.
  always_comb begin
    envScaled  = MUL_W'(env1_q) * MUL_W'($signed({1'b0, modIndex1_q}));
    envTerm    = ENV_W'(envScaled >>> (M_W - 1));
    envelope_d = modeSc1_q ? envTerm : (FS_ENV + envTerm);
  end

  // Stage 2 holds the finished envelope next to its carrier sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid2_q    <= 1'b0;
      carrier2_q  <= '0;
      env2_q      <= '0;
      envelope2_q <= '0;
    end else begin
      valid2_q    <= valid1_q;
      carrier2_q  <= carrier1_q;
      env2_q      <= env1_q;
      envelope2_q <= envelope_d;
    end
  end

  // Stage 3 forms the full-width carrier-times-envelope product. No bits
  // are dropped, so the rescale later on is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid3_q   <= 1'b0;
      carrier3_q <= '0;
      env3_q     <= '0;
      product3_q <= '0;
    end else begin
      valid3_q   <= valid2_q;
      carrier3_q <= carrier2_q;
      env3_q     <= env2_q;
      product3_q <= PROD_W'(carrier2_q) * PROD_W'(envelope2_q);
    end
  end

  // Rescale by the carrier full-scale exponent with a floor shift. Then
  // clip into the signed OUT_W range and flag whenever clipping happened.
  always_comb begin
    rescaled = product3_q >>> (DATA_W - 1);
    amOut_d  = OUT_W'(rescaled);
    sat_d    = 1'b0;
    if (rescaled > OUT_MAX) begin
      amOut_d = OUT_W'(OUT_MAX);
      sat_d   = 1'b1;
    end else if (rescaled < OUT_MIN) begin
      amOut_d = OUT_W'(OUT_MIN);
      sat_d   = 1'b1;
    end
  end

  // Output register. All sample outputs and sat refresh only when a valid
  // sample arrives, so they stay coherent and hold their values through
  // gaps in the enable pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q      <= 1'b0;
      sat_q           <= 1'b0;
      amOut_q         <= '0;
      sinCarrierOut_q <= '0;
      sinEnvOut_q     <= '0;
    end else begin
      outValid_q <= valid3_q;
      if (valid3_q) begin
        sat_q           <= sat_d;
        amOut_q         <= amOut_d;
        sinCarrierOut_q <= carrier3_q;
        sinEnvOut_q     <= env3_q;
      end
    end
  end

  assign ddsBus.out_valid   = outValid_q;
  assign ddsBus.sat         = sat_q;
  assign ddsBus.am_out      = amOut_q;
  assign ddsBus.sin_carrier = sinCarrierOut_q;
  assign ddsBus.sin_env     = sinEnvOut_q;

endmodule

// File: tb/tb_am_dds_modulator.sv
// tb_am_dds_modulator
// Scoreboard bench for am_dds_modulator. The stimulus process drives the
// interface and advances a behavioural model. For every enable it pushes
// the expected sample and its due edge into a queue. A monitor pops an
// entry whenever out_valid is seen and compares it. Outputs must hold
// while out_valid is low.
module tb_am_dds_modulator;

  localparam int PHASE_W = 24;
  localparam int LUT_AW  = 8;
  localparam int DATA_W  = 16;
  localparam int M_W     = 8;
  localparam int OUT_W   = 17;

  localparam longint PHASE_MOD = longint'(1) << PHASE_W;
  localparam longint FS        = (longint'(1) << (DATA_W - 1)) - 1;
  localparam longint OUT_HI    = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint OUT_LO    = -(longint'(1) << (OUT_W - 1));
  localparam real    PI        = 3.14159265358979323846;

  typedef struct {
    int     due;
    longint carrier;
    longint env;
    longint am;
    longint sat;
  } expected_t;

  logic clk;
  logic rst;

  am_dds_if #(.PHASE_W(PHASE_W), .DATA_W(DATA_W), .M_W(M_W), .OUT_W(OUT_W)) bus ();

  am_dds_modulator #(
    .PHASE_W(PHASE_W),
    .LUT_AW (LUT_AW),
    .DATA_W (DATA_W),
    .M_W    (M_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ddsBus(bus)
  );

  expected_t expQ[$];
  int        edgeCount = 0;
  int        checkCount = 0;
  int        passCount = 0;

  longint    lastCarrier = 0;
  longint    lastEnv = 0;
  longint    lastAm = 0;
  longint    lastSat = 0;

  longint    modelAccC = 0;
  longint    modelAccE = 0;
  longint    modelFcwC = 0;
  longint    modelFcwE = 0;
  longint    modelM = 128;
  bit        modelSc = 1'b0;

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and prints a FAIL line on mismatch.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  // Floor division for a positive divisor.
  function automatic longint floorDiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) begin
      q = q - 1;
    end
    return q;
  endfunction

  // Ideal sine sample of a phase. The phase is split into a quadrant and a
  // table step. The table is read backwards in falling quadrants, and the
  // sample is negated in the second half of the circle.
  function automatic longint sineRef(input longint phase);
    longint quarter;
    longint quad;
    longint idx;
    longint val;
    quarter = longint'(1) << (PHASE_W - 2);
    quad    = phase / quarter;
    idx     = (phase % quarter) / (quarter / (longint'(1) << LUT_AW));
    if (quad % 2 == 1) begin
      idx = (longint'(1) << LUT_AW) - 1 - idx;
    end
    val = longint'($rtoi(real'(FS) * $sin(PI / 2.0 * real'(idx) / real'(longint'(1) << LUT_AW)) + 0.5));
    return (quad >= 2) ? -val : val;
  endfunction

  // Full AM sample from the two phases and the modulation settings.
  function automatic expected_t sampleRef(input longint phC, input longint phE,
                                          input longint m, input bit sc, input int due);
    expected_t e;
    longint t;
    longint envelope;
    longint r;
    e.due     = due;
    e.carrier = sineRef(phC);
    e.env     = sineRef(phE);
    t         = floorDiv(e.env * m, longint'(1) << (M_W - 1));
    envelope  = sc ? t : FS + t;
    r         = floorDiv(e.carrier * envelope, longint'(1) << (DATA_W - 1));
    e.sat     = 0;
    e.am      = r;
    if (r > OUT_HI) begin
      e.am  = OUT_HI;
      e.sat = 1;
    end else if (r < OUT_LO) begin
      e.am  = OUT_LO;
      e.sat = 1;
    end
    return e;
  endfunction

  // Drives one cycle of inputs at the falling edge and advances the model
  // to match the coming rising edge.
  task automatic applyStimulus(input bit en, input bit clr, input bit load,
                               input longint fcwC, input longint fcwE,
                               input longint m, input bit sc);
    @(negedge clk);
    bus.en              = en;
    bus.sync_clr        = clr;
    bus.cfg_load        = load;
    bus.cfg_fcw_carrier = PHASE_W'(fcwC);
    bus.cfg_fcw_env     = PHASE_W'(fcwE);
    bus.cfg_mod_index   = M_W'(m);
    bus.cfg_mode_sc     = sc;
    if (en) begin
      expQ.push_back(sampleRef(modelAccC, modelAccE, modelM, modelSc, edgeCount + 4));
    end
    if (clr) begin
      modelAccC = 0;
      modelAccE = 0;
    end else if (en) begin
      modelAccC = (modelAccC + modelFcwC) % PHASE_MOD;
      modelAccE = (modelAccE + modelFcwE) % PHASE_MOD;
    end
    if (load) begin
      modelFcwC = fcwC % PHASE_MOD;
      modelFcwE = fcwE % PHASE_MOD;
      modelM    = m;
      modelSc   = sc;
    end
  endtask

  // Plain enable cycles with no configuration change.
  task automatic runEnabled(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    end
  endtask

  // Idle cycles.
  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    end
  endtask

  // Holds rst for the given number of edges. In-flight samples are dropped,
  // and the model returns to its power-up state.
  task automatic doReset(input int cycles);
    @(negedge clk);
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.sync_clr = 1'b0;
    bus.cfg_load = 1'b0;
    expQ.delete();
    modelAccC   = 0;
    modelAccE   = 0;
    modelFcwC   = 0;
    modelFcwE   = 0;
    modelM      = 128;
    modelSc     = 1'b0;
    lastCarrier = 0;
    lastEnv     = 0;
    lastAm      = 0;
    lastSat     = 0;
    repeat (cycles - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor, sampling 1 time unit after each rising edge. A valid output
  // must match the head of the queue on its due edge. Without valid, the
  // outputs must equal the last accepted sample (zero after reset).
  always begin
    expected_t e;
    @(posedge clk);
    edgeCount++;
    #1;
    if (bus.out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("valid_expected", longint'(bus.out_valid), 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("valid_edge", edgeCount, e.due);
        checkOutput("sin_carrier", longint'(bus.sin_carrier), e.carrier);
        checkOutput("sin_env", longint'(bus.sin_env), e.env);
        checkOutput("am_out", longint'(bus.am_out), e.am);
        checkOutput("sat", longint'(bus.sat), e.sat);
        lastCarrier = e.carrier;
        lastEnv     = e.env;
        lastAm      = e.am;
        lastSat     = e.sat;
      end
    end else begin
      if (expQ.size() > 0 && expQ[0].due <= edgeCount) begin
        checkOutput("valid_missing", longint'(bus.out_valid), 1);
        void'(expQ.pop_front());
      end
      checkOutput("hold_am_out", longint'(bus.am_out), lastAm);
      checkOutput("hold_sat", longint'(bus.sat), lastSat);
      checkOutput("hold_sin_carrier", longint'(bus.sin_carrier), lastCarrier);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, a randomized stretch with a mid-stream reset, then
  // a bounded drain of the scoreboard.
  initial begin
    rst                 = 1'b1;
    bus.en              = 1'b0;
    bus.sync_clr        = 1'b0;
    bus.cfg_load        = 1'b0;
    bus.cfg_fcw_carrier = '0;
    bus.cfg_fcw_env     = '0;
    bus.cfg_mod_index   = '0;
    bus.cfg_mode_sc     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runIdle(3);

    $display("[TB] quadrant symmetry, full carrier, m=1");
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h400000, 0, 128, 1'b0);
    runEnabled(8);
    runIdle(5);

    $display("[TB] overmodulation m=255");
    applyStimulus(1'b0, 1'b1, 1'b1, 24'h400000, 24'h400000, 255, 1'b0);
    runEnabled(4);
    runIdle(5);

    $display("[TB] suppressed carrier m=1");
    applyStimulus(1'b0, 1'b1, 1'b1, 24'h400000, 24'h400000, 128, 1'b1);
    runEnabled(4);
    runIdle(5);

    $display("[TB] enable gating");
    applyStimulus(1'b0, 1'b1, 1'b1, 24'h123457, 24'h010203, 100, 1'b0);
    runEnabled(1);
    runIdle(2);
    runEnabled(1);
    runIdle(6);
    runEnabled(1);
    runIdle(5);

    $display("[TB] config load, wrap and clear alignment");
    applyStimulus(1'b1, 1'b0, 1'b1, 24'hFFFFFF, 24'h000100, 200, 1'b0);
    runEnabled(4);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    runEnabled(2);
    runIdle(5);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h0A0B0C, 24'h001122, 180, 1'b0);
    runEnabled(2);
    doReset(2);
    runIdle(6);
    runEnabled(2);
    runIdle(5);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        runEnabled(2);
        doReset(2);
        runIdle(3);
      end
      applyStimulus($urandom_range(0, 9) < 7,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 19) == 0,
                    longint'($urandom_range(0, 32'hFFFFFF)),
                    longint'($urandom_range(0, 32'hFFFFFF)),
                    longint'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
    end

    runIdle(1);
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      runIdle(1);
    end
    checkOutput("scoreboard_drained", longint'(expQ.size()), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
